// File: rtl/outlier_drain.sv
// Outlier drain: after the Controller signals done, pops each outlier index
// from the FIFO, fetches its x/y/z from point memory and streams one
// coordinate record per in-range index on a valid/ready interface.
module outlier_drain #(
   parameter int unsigned N                = 16,
   parameter int unsigned POINT_CLOUD_SIZE = 17500
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         done,
   input  logic         empty,
   output logic         read_fifo,
   input  logic [N-1:0] outlier_pos_fifo,
   output logic         mem_rd_en,
   output logic [N-1:0] mem_addr,
   input  logic [N-1:0] mem_x,
   input  logic [N-1:0] mem_y,
   input  logic [N-1:0] mem_z,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_x,
   output logic [N-1:0] out_y,
   output logic [N-1:0] out_z,
   output logic [N-1:0] out_index,
   output logic         out_last,
   output logic [N-1:0] outlier_count,
   output logic         range_err,
   output logic         drain_done
);

   localparam logic [N-1:0] PcSize = N'(POINT_CLOUD_SIZE);

   typedef enum logic [2:0] {
      StIdle,
      StPop,
      StFetch,
      StCapture,
      StOut,
      StFinish
   } state_t;

   state_t       state;
   logic [N-1:0] idx;
   logic         fifo_in_range;

   assign fifo_in_range = (outlier_pos_fifo < PcSize);

   // Memory request is issued straight from the FIFO data in FETCH so the
   // read data lands in CAPTURE, keeping the record loop at 4 cycles.
   assign mem_rd_en = (state == StFetch) && fifo_in_range;
   assign mem_addr  = mem_rd_en ? outlier_pos_fifo : '0;

   // Drain FSM with registered stream, pop and status outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= StIdle;
         idx           <= '0;
         read_fifo     <= 1'b0;
         out_valid     <= 1'b0;
         out_x         <= '0;
         out_y         <= '0;
         out_z         <= '0;
         out_index     <= '0;
         out_last      <= 1'b0;
         outlier_count <= '0;
         range_err     <= 1'b0;
         drain_done    <= 1'b0;
      end else begin
         read_fifo <= 1'b0;
         unique case (state)
            StIdle: begin
               if (done) begin
                  if (!empty) begin
                     state     <= StPop;
                     read_fifo <= 1'b1;
                  end else begin
                     state      <= StFinish;
                     drain_done <= 1'b1;
                  end
               end
            end
            StPop: begin
               state <= StFetch;
            end
            StFetch: begin
               idx <= outlier_pos_fifo;
               if (fifo_in_range) begin
                  state <= StCapture;
               end else begin
                  // Out-of-range entry is dropped without a record or count.
                  range_err <= 1'b1;
                  if (!empty) begin
                     state     <= StPop;
                     read_fifo <= 1'b1;
                  end else begin
                     state      <= StFinish;
                     drain_done <= 1'b1;
                  end
               end
            end
            StCapture: begin
               out_x     <= mem_x;
               out_y     <= mem_y;
               out_z     <= mem_z;
               out_index <= idx;
               // empty already reflects this record's pop.
               out_last  <= empty;
               out_valid <= 1'b1;
               state     <= StOut;
            end
            StOut: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (outlier_count != '1) begin
                     outlier_count <= outlier_count + 1'b1;
                  end
                  if (out_last) begin
                     state      <= StFinish;
                     drain_done <= 1'b1;
                  end else begin
                     state     <= StPop;
                     read_fifo <= 1'b1;
                  end
               end
            end
            StFinish: begin
               drain_done <= 1'b1;
               out_valid  <= 1'b0;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_outlier_drain.sv
// Directed self-checking bench for outlier_drain with a behavioural FIFO and
// point memory where memory[i] = (i, i+1, i+2).
module tb_outlier_drain;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        done = 1'b0;
   logic        empty;
   logic        read_fifo;
   logic [15:0] outlier_pos_fifo = '0;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_x = '0;
   logic [15:0] mem_y = '0;
   logic [15:0] mem_z = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_x;
   logic [15:0] out_y;
   logic [15:0] out_z;
   logic [15:0] out_index;
   logic        out_last;
   logic [15:0] outlier_count;
   logic        range_err;
   logic        drain_done;

   logic [15:0] fifo_mem [0:7];
   int          wr_cnt = 0;
   int          rd_ptr = 0;
   logic        fifo_clear = 1'b1;
   int          pop_cnt = 0;
   int          cyc = 0;

   int          checks = 0;
   int          errors = 0;
   int          pop_base;
   int          t_first;
   int          rec_cyc;

   outlier_drain #(
      .N               (16),
      .POINT_CLOUD_SIZE(17500)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .done            (done),
      .empty           (empty),
      .read_fifo       (read_fifo),
      .outlier_pos_fifo(outlier_pos_fifo),
      .mem_rd_en       (mem_rd_en),
      .mem_addr        (mem_addr),
      .mem_x           (mem_x),
      .mem_y           (mem_y),
      .mem_z           (mem_z),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_x           (out_x),
      .out_y           (out_y),
      .out_z           (out_z),
      .out_index       (out_index),
      .out_last        (out_last),
      .outlier_count   (outlier_count),
      .range_err       (range_err),
      .drain_done      (drain_done)
   );

   always #5 clock = ~clock;

   assign empty = (rd_ptr == wr_cnt);

   // FIFO model: data valid the cycle after the pop, empty updates at once.
   always @(posedge clock) begin
      if (fifo_clear) begin
         rd_ptr <= 0;
      end else if (read_fifo) begin
         outlier_pos_fifo <= fifo_mem[rd_ptr[2:0]];
         rd_ptr           <= rd_ptr + 1;
      end
   end

   // Point memory model with one-cycle read latency.
   always @(posedge clock) begin
      if (mem_rd_en) begin
         mem_x <= mem_addr;
         mem_y <= mem_addr + 16'd1;
         mem_z <= mem_addr + 16'd2;
      end
   end

   // Pop and cycle counters.
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (read_fifo) pop_cnt <= pop_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_test(input int n, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c);
      @(negedge clock);
      reset      = 1'b0;
      done       = 1'b0;
      fifo_clear = 1'b1;
      fifo_mem[0] = a;
      fifo_mem[1] = b;
      fifo_mem[2] = c;
      wr_cnt     = n;
      @(negedge clock);
      @(negedge clock);
      reset      = 1'b1;
      fifo_clear = 1'b0;
      pop_base   = pop_cnt;
   endtask

   task automatic expect_record(input string tag, input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] z, input logic [15:0] idx,
                                input logic last);
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (out_valid) begin
            seen = 1;
            break;
         end
      end
      check({tag, " valid"}, 64'(seen), 64'd1);
      if (seen) begin
         rec_cyc = cyc;
         check({tag, " xyz"}, {out_x, out_y, out_z}, {x, y, z});
         check({tag, " index"}, 64'(out_index), 64'(idx));
         check({tag, " last"}, 64'(out_last), 64'(last));
      end
   endtask

   task automatic wait_drain_done(input string tag, input int limit);
      bit seen = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clock);
         if (drain_done) begin
            seen = 1;
            break;
         end
      end
      check({tag, " drain_done"}, 64'(seen), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      start_test(0, 16'd0, 16'd0, 16'd0);
      check("reset ctrl", {read_fifo, mem_rd_en, out_valid, out_last, range_err, drain_done},
            64'd0);
      check("reset data", {out_x, out_y, out_z, out_index}, 64'd0);
      check("reset count/addr", {outlier_count, mem_addr}, 64'd0);

      // Normal drain
      start_test(3, 16'd5, 16'd100, 16'd17499);
      out_ready = 1'b1;
      done      = 1'b1;
      expect_record("norm r0", 16'd5, 16'd6, 16'd7, 16'd5, 1'b0);
      t_first = rec_cyc;
      expect_record("norm r1", 16'd100, 16'd101, 16'd102, 16'd100, 1'b0);
      check("norm spacing", 64'(rec_cyc - t_first), 64'd4);
      expect_record("norm r2", 16'd17499, 16'd17500, 16'd17501, 16'd17499, 1'b1);
      wait_drain_done("norm", 5);
      check("norm count", 64'(outlier_count), 64'd3);
      check("norm pops", 64'(pop_cnt - pop_base), 64'd3);
      check("norm range_err", 64'(range_err), 64'd0);
      check("norm valid low", 64'(out_valid), 64'd0);

      // Zero outliers
      start_test(0, 16'd0, 16'd0, 16'd0);
      done = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("zero drain_done", 64'(drain_done), 64'd1);
      check("zero valid", 64'(out_valid), 64'd0);
      check("zero count", 64'(outlier_count), 64'd0);
      check("zero pops", 64'(pop_cnt - pop_base), 64'd0);

      // Backpressure
      start_test(2, 16'd7, 16'd8, 16'd0);
      out_ready = 1'b0;
      done      = 1'b1;
      expect_record("bp r0", 16'd7, 16'd8, 16'd9, 16'd7, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("bp hold", {out_valid, out_last, out_x, out_y, out_z},
               {1'b1, 1'b0, 16'd7, 16'd8, 16'd9});
      end
      check("bp no pop", 64'(pop_cnt - pop_base), 64'd1);
      check("bp count held", 64'(outlier_count), 64'd0);
      out_ready = 1'b1;
      expect_record("bp r1", 16'd8, 16'd9, 16'd10, 16'd8, 1'b1);
      wait_drain_done("bp", 5);
      check("bp count", 64'(outlier_count), 64'd2);

      // Range error in the middle
      start_test(3, 16'd3, 16'd17500, 16'd9);
      done = 1'b1;
      expect_record("rng r0", 16'd3, 16'd4, 16'd5, 16'd3, 1'b0);
      expect_record("rng r1", 16'd9, 16'd10, 16'd11, 16'd9, 1'b1);
      wait_drain_done("rng", 5);
      check("rng range_err", 64'(range_err), 64'd1);
      check("rng count", 64'(outlier_count), 64'd2);
      check("rng pops", 64'(pop_cnt - pop_base), 64'd3);

      // Range error on the last entry
      start_test(2, 16'd3, 16'd17500, 16'd0);
      done = 1'b1;
      expect_record("rlast r0", 16'd3, 16'd4, 16'd5, 16'd3, 1'b0);
      wait_drain_done("rlast", 10);
      check("rlast range_err", 64'(range_err), 64'd1);
      check("rlast count", 64'(outlier_count), 64'd1);
      check("rlast pops", 64'(pop_cnt - pop_base), 64'd2);

      // Reset mid-drain, FIFO keeps its remaining entries
      start_test(3, 16'd1, 16'd2, 16'd3);
      out_ready = 1'b0;
      done      = 1'b1;
      expect_record("rst r0", 16'd1, 16'd2, 16'd3, 16'd1, 1'b0);
      reset = 1'b0;
      @(negedge clock);
      check("rst ctrl", {read_fifo, mem_rd_en, out_valid, out_last, range_err, drain_done},
            64'd0);
      check("rst data", {out_x, out_y, out_z, out_index}, 64'd0);
      check("rst count", 64'(outlier_count), 64'd0);
      @(negedge clock);
      check("rst no pop", 64'(pop_cnt - pop_base), 64'd1);
      reset     = 1'b1;
      out_ready = 1'b1;
      expect_record("rst r1", 16'd2, 16'd3, 16'd4, 16'd2, 1'b0);
      expect_record("rst r2", 16'd3, 16'd4, 16'd5, 16'd3, 1'b1);
      wait_drain_done("rst", 5);
      check("rst final count", 64'(outlier_count), 64'd2);
      check("rst pops", 64'(pop_cnt - pop_base), 64'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/outlier_drain.md
Name: outlier_drain

Overview:
- Downstream stage of the denoising Controller.
- After the Controller raises done, this block drains its outlier-index FIFO one entry at a time.
- For each index it fetches the x/y/z coordinates from the point-cloud memory and emits one coordinate record per outlier on a valid/ready stream for the DMA/writer.
- It replaces the behavioural file-dump logic with synthesizable RTL.

Parameters:
- N, 16, width of one coordinate and of a point index.
- POINT_CLOUD_SIZE, 17500, number of valid points; indices >= this are out of range.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- done  in  1  Controller done; level.
- empty  in  1  outlier FIFO empty flag.
- read_fifo  out  1  FIFO pop strobe.
- outlier_pos_fifo  in  N  FIFO read data; valid the cycle after read_fifo.
- mem_rd_en  out  1  point-memory read enable.
- mem_addr  out  N  point-memory address.
- mem_x, mem_y, mem_z  in  N each  point-memory data; valid the cycle after mem_rd_en.
- out_valid  out  1  record valid.
- out_ready  in  1  consumer ready.
- out_x, out_y, out_z  out  N each  outlier coordinates.
- out_index  out  N  outlier point index.
- out_last  out  1  high with the final record.
- outlier_count  out  N  records emitted; saturates at 2^N-1.
- range_err  out  1  sticky flag: an out-of-range index was popped.
- drain_done  out  1  sticky flag: drain complete.

Behaviour:
- **Reset** (reset==0 at a rising edge): state=IDLE. All outputs are 0: read_fifo, mem_rd_en, mem_addr, out_valid, out_x/y/z, out_index, out_last, outlier_count, range_err, drain_done. Reset mid-drain aborts immediately; no further pops; the FIFO is not flushed.
- **FSM states:** IDLE, POP, FETCH, CAPTURE, OUT, FINISH.
- **IDLE:**
  - done==1 and empty==0 -> POP.
  - done==1 and empty==1 -> FINISH. Zero-outlier case: no record emitted.
  - Otherwise stay.
- **Start latching:** done is sampled only in IDLE. Deassertion of done after leaving IDLE is ignored.
- **POP:** read_fifo=1 for exactly this one cycle -> FETCH.
- **FETCH:** register idx = outlier_pos_fifo.
  - idx < POINT_CLOUD_SIZE: mem_addr=idx, mem_rd_en=1 for one cycle -> CAPTURE.
  - idx >= POINT_CLOUD_SIZE: range_err<=1 and the entry is skipped (no record, no count). Then -> POP if empty==0, else -> FINISH.
- **CAPTURE:**
  - Register out_x/y/z <= mem_x/y/z and out_index <= idx.
  - out_last <= empty. By this cycle empty reflects the pop, since the FIFO updates empty within one cycle of read_fifo.
  - -> OUT.
- **OUT:**
  - out_valid=1. out_* data and out_last are held stable while out_ready==0.
  - Transfer occurs when out_valid & out_ready at the edge. Then outlier_count increments, saturating, and out_valid drops next cycle.
  - After transfer: out_last==1 -> FINISH; else -> POP.
- **Throughput:** 4 cycles per record with out_ready held high. There is no pipelining across records.
- **FINISH:** drain_done=1 and out_valid=0. Stays in FINISH until reset.
- **read_fifo** is never asserted while empty==1 is sampled in the same decision cycle. No double pop is allowed between consecutive records.
- **Index width:** the index is used unmodified as the address. The comparison against POINT_CLOUD_SIZE is unsigned, N bits.

Test Plan:
- **Normal drain:** FIFO preloaded with {5, 100, 17499}; memory[i]=(i, i+1, i+2); done=1; out_ready=1 -> three records (5,6,7,idx5), (100,101,102,idx100), (17499,17500,17501,idx17499); out_last only on the third; outlier_count=3; drain_done=1; exactly 3 read_fifo pulses.
- **Zero outliers:** empty=1, done=1 -> no out_valid; drain_done=1 within 2 cycles; outlier_count=0; read_fifo never asserted.
- **Backpressure:** FIFO {7, 8}; out_ready=0 for 10 cycles on the first record -> out_valid held high with data (7,8,9) stable; no second pop until transfer; count ends at 2.
- **Range error:** FIFO {3, 17500, 9} -> records for 3 and 9 only; range_err=1; count=2; out_last on index 9.
- **Range error on last entry:** FIFO {3, 17500} -> the record for 3 has out_last=0. Because out_last is sampled as empty in CAPTURE, and 17500 is still in the FIFO at that point, it is decided to be 0. Then the skip -> FINISH; drain_done=1; range_err=1.
- **Reset mid-drain:** FIFO {1, 2, 3}; assert reset=0 while in OUT of the first record -> next cycle all outputs 0 and state IDLE; with done=1 after release, draining resumes from the remaining FIFO entries {2, 3}.
